// File: rtl/monster_shot_pkg.sv
// Shared types and default constants for the monster shot scheduler.
package monster_shot_pkg;

    // Signed screen coordinate, top-left of a shot object.
    typedef logic signed [10:0] coord_t;

    // Scheduler FSM: IDLE accepts fires and frame starts, MOVE walks the slots.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MOVE = 1'b1
    } state_e;

    localparam int SHOT_SPEED_DEF    = 4;
    localparam int SCREEN_BOTTOM_DEF = 480;
    localparam int FIRE_COOLDOWN_DEF = 30;

endpackage

// File: rtl/shot_slot_alloc.sv
// Lowest-index free slot finder over the shot active mask.
module shot_slot_alloc #(
    parameter int NUM_SHOTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_SHOTS-1:0] active_mask,
    output logic [IDX_W-1:0]     free_idx,
    output logic                 any_free
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (!active_mask[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/monster_shot_scheduler.sv
// Enemy shot pool: allocates fire requests to free slots and moves every
// active shot down the screen once per frame, one slot per clock.
module monster_shot_scheduler
    import monster_shot_pkg::*;
#(
    parameter int NUM_SHOTS     = 4,
    parameter int SHOT_SPEED    = SHOT_SPEED_DEF,
    parameter int SCREEN_BOTTOM = SCREEN_BOTTOM_DEF,
    parameter int FIRE_COOLDOWN = FIRE_COOLDOWN_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    game_enable,
    input  logic                    fire_req,
    input  logic signed [10:0]      fire_x,
    input  logic signed [10:0]      fire_y,
    output logic                    fire_ack,
    input  logic [NUM_SHOTS-1:0]    shot_hit,
    output logic [NUM_SHOTS-1:0]    shot_active,
    output logic [NUM_SHOTS*11-1:0] shot_x,
    output logic [NUM_SHOTS*11-1:0] shot_y,
    output logic                    busy
);

    localparam int IDX_W = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
    localparam int CD_W  = $clog2(FIRE_COOLDOWN + 2);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SHOTS - 1);
    localparam logic signed [11:0] SPEED_S  = 12'(SHOT_SPEED);
    localparam logic signed [11:0] BOTTOM_S = 12'(SCREEN_BOTTOM);

    state_e                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [CD_W-1:0]        r_cooldown;
    logic [NUM_SHOTS-1:0]   r_active;
    coord_t                 r_x [NUM_SHOTS];
    coord_t                 r_y [NUM_SHOTS];
    logic                   r_fire_ack;

    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_any_free;
    logic                   w_fire;
    logic                   w_last;
    logic signed [11:0]     w_y_sum;
    logic                   w_retire;

    shot_slot_alloc #(
        .NUM_SHOTS (NUM_SHOTS),
        .IDX_W     (IDX_W)
    ) u_alloc (
        .active_mask (r_active),
        .free_idx    (w_free_idx),
        .any_free    (w_any_free)
    );

    // Fire acceptance and the move arithmetic for the slot under the index.
    always_comb begin
        w_fire   = (r_state == ST_IDLE) && game_enable && !startOfFrame &&
                   fire_req && (r_cooldown == '0) && w_any_free;
        w_last   = (r_idx == LAST_IDX);
        // 12-bit sum so a shot near the bottom cannot wrap to a small Y.
        w_y_sum  = {r_y[r_idx][10], r_y[r_idx]} + SPEED_S;
        w_retire = (w_y_sum >= BOTTOM_S);
    end

    // Scheduler state, slot table and cooldown.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_cooldown <= '0;
            r_active   <= '0;
            r_fire_ack <= 1'b0;
            // NOTE: the coordinate table is reset because its values are visible
            // on the ports; a purely internal storage array would not need this.
            for (int i = 0; i < NUM_SHOTS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else begin
            r_fire_ack <= w_fire;
            case (r_state)
                ST_IDLE: begin
                    if (game_enable && startOfFrame) begin
                        r_state <= ST_MOVE;
                        r_idx   <= '0;
                    end else if (w_fire) begin
                        r_x[w_free_idx]      <= fire_x;
                        r_y[w_free_idx]      <= fire_y;
                        r_active[w_free_idx] <= 1'b1;
                        r_cooldown           <= CD_W'(FIRE_COOLDOWN);
                    end
                end
                ST_MOVE: begin
                    if (game_enable) begin
                        if (r_active[r_idx] && !shot_hit[r_idx]) begin
                            if (w_retire) begin
                                r_active[r_idx] <= 1'b0;
                            end else begin
                                r_y[r_idx] <= w_y_sum[10:0];
                            end
                        end
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_idx   <= '0;
                            if (r_cooldown != '0) begin
                                r_cooldown <= r_cooldown - CD_W'(1);
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // NOTE: the last non-blocking assignment to a bit in this block wins,
            // so placing the hit clear here gives it priority over move and fire.
            for (int i = 0; i < NUM_SHOTS; i++) begin
                if (shot_hit[i]) begin
                    r_active[i] <= 1'b0;
                end
            end
        end
    end

    // Pack the slot table onto the flat output buses.
    always_comb begin
        shot_x = '0;
        shot_y = '0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            shot_x[11*i +: 11] = r_x[i];
            shot_y[11*i +: 11] = r_y[i];
        end
    end

    assign shot_active = r_active;
    assign fire_ack    = r_fire_ack;
    assign busy        = (r_state == ST_MOVE);

endmodule

// File: tb/tb_monster_shot_scheduler.sv
// Scoreboard bench for monster_shot_scheduler: directed scenarios followed by
// randomized traffic, all checked against a slot-pool reference model.
module tb_monster_shot_scheduler;

    localparam int N      = 4;
    localparam int SPEED  = 4;
    localparam int BOTTOM = 480;
    localparam int COOL   = 30;

    logic                clk   = 1'b0;
    logic                reset = 1'b1;
    logic                sof   = 1'b0;
    logic                ge    = 1'b1;
    logic                freq  = 1'b0;
    logic signed [10:0]  fx    = '0;
    logic signed [10:0]  fy    = '0;
    logic [N-1:0]        hit   = '0;
    logic                fack;
    logic [N-1:0]        act;
    logic [N*11-1:0]     sx;
    logic [N*11-1:0]     sy;
    logic                busy;

    monster_shot_scheduler #(
        .NUM_SHOTS     (N),
        .SHOT_SPEED    (SPEED),
        .SCREEN_BOTTOM (BOTTOM),
        .FIRE_COOLDOWN (COOL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (sof),
        .game_enable  (ge),
        .fire_req     (freq),
        .fire_x       (fx),
        .fire_y       (fy),
        .fire_ack     (fack),
        .shot_hit     (hit),
        .shot_active  (act),
        .shot_x       (sx),
        .shot_y       (sy),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [63:0] actual,
                         input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int cyc;
        int slot;
        int x;
        int y;
    } ack_t;

    typedef struct {
        int              cyc;
        bit              abort;
        logic [N-1:0]    act;
        logic [N*11-1:0] ys;
    } frame_t;

    ack_t   ack_q[$];
    frame_t frame_q[$];

    bit m_act[N];
    int m_x[N];
    int m_y[N];
    int m_cool  = 0;
    int m_left  = 0;   // slots still to visit in the current frame, 0 = idle
    bit m_acked = 0;
    int n_acks  = 0;

    function automatic void push_frame(input int c, input bit ab);
        frame_t f;
        f.cyc   = c;
        f.abort = ab;
        f.act   = '0;
        f.ys    = '0;
        for (int i = 0; i < N; i++) begin
            f.act[i]        = m_act[i];
            f.ys[11*i +: 11] = 11'(m_y[i]);
        end
        frame_q.push_back(f);
    endfunction

    // Applies the inputs currently driven to the model, as of the next clock edge.
    function automatic void model_step();
        int nc    = cyc + 1;
        bit ended = 0;
        m_acked = 0;
        if (reset) begin
            if (m_left > 0) push_frame(nc, 1'b1);
            for (int i = 0; i < N; i++) begin
                m_act[i] = 0;
                m_x[i]   = 0;
                m_y[i]   = 0;
            end
            m_cool = 0;
            m_left = 0;
            return;
        end
        if (m_left > 0) begin
            if (ge) begin
                int s = N - m_left;
                if (m_act[s] && !hit[s]) begin
                    if (m_y[s] + SPEED >= BOTTOM) m_act[s] = 0;
                    else m_y[s] = m_y[s] + SPEED;
                end
                m_left--;
                ended = (m_left == 0);
            end
        end else if (ge && sof) begin
            m_left = N;
        end else if (ge && freq && m_cool == 0) begin
            int k = -1;
            for (int i = N - 1; i >= 0; i--) if (!m_act[i]) k = i;
            if (k >= 0) begin
                m_act[k] = 1;
                m_x[k]   = fx;
                m_y[k]   = fy;
                m_cool   = COOL;
                m_acked  = 1;
                ack_q.push_back('{nc, k, int'(fx), int'(fy)});
            end
        end
        for (int i = 0; i < N; i++) if (hit[i]) m_act[i] = 0;
        if (ended) begin
            if (m_cool > 0) m_cool--;
            push_frame(nc, 1'b0);
        end
    endfunction

    // ---------------- monitor ----------------
    bit prev_busy = 0;
    initial begin
        ack_t   a;
        frame_t f;
        forever begin
            @(negedge clk);
            while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                check("ack_missing_expected_cycle", cyc, ack_q[0].cyc);
                void'(ack_q.pop_front());
            end
            while (frame_q.size() > 0 && frame_q[0].cyc < cyc) begin
                check("frame_end_missing_expected_cycle", cyc, frame_q[0].cyc);
                void'(frame_q.pop_front());
            end
            if (fack === 1'b1) begin
                if (ack_q.size() == 0) begin
                    check("ack_unexpected_at_cycle", cyc, -1);
                end else begin
                    a = ack_q.pop_front();
                    check("ack_cycle", cyc, a.cyc);
                    check("ack_slot_active", act[a.slot], 1);
                    check("ack_slot_x", $signed(sx[11*a.slot +: 11]), a.x);
                    check("ack_slot_y", $signed(sy[11*a.slot +: 11]), a.y);
                end
            end
            if (prev_busy && busy === 1'b0) begin
                if (frame_q.size() == 0) begin
                    check("frame_end_unexpected_at_cycle", cyc, -1);
                end else begin
                    f = frame_q.pop_front();
                    check("frame_end_cycle", cyc, f.cyc);
                    if (f.abort) begin
                        check("abort_active", act, 0);
                        check("abort_x", sx, 0);
                        check("abort_y", sy, 0);
                        check("abort_ack", fack, 0);
                    end else begin
                        check("frame_active", act, f.act);
                        for (int i = 0; i < N; i++)
                            if (f.act[i])
                                check("frame_y", $signed(sy[11*i +: 11]), $signed(f.ys[11*i +: 11]));
                    end
                end
            end
            prev_busy = (busy === 1'b1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(negedge clk);
        if (m_acked) begin
            freq = 1'b0;
            n_acks++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic frame();
        sof = 1'b1;
        tick();
        sof = 1'b0;
        idle(N + 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic fire_wait(input int x, input int y, output int frames);
        fx     = 11'(x);
        fy     = 11'(y);
        freq   = 1'b1;
        frames = 0;
        tick();
        while (freq && frames < 200) begin
            frame();
            frames++;
        end
        if (freq) begin
            check("fire_wait_timeout_frames", frames, -1);
            freq = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_active"}, act, 0);
        check({tag, "_x"}, sx, 0);
        check({tag, "_y"}, sy, 0);
        check({tag, "_ack"}, fack, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int frames;
        int cnt;
        int acks0;

        @(negedge clk);
        idle(2);
        check_all_zero("reset");
        reset = 1'b0;

        // First fire lands in slot 0 with one-cycle latency.
        fx = 11'sd100; fy = 11'sd50; freq = 1'b1;
        tick();
        check("first_ack", fack, 1);
        check("first_active", act, 4'b0001);
        check("first_x", $signed(sx[10:0]), 100);
        check("first_y", $signed(sy[10:0]), 50);

        // One frame: busy for N cycles, slot 0 moves down by SPEED.
        sof = 1'b1;
        tick();
        sof = 1'b0;
        cnt = 0;
        for (int i = 0; i < N + 1; i++) begin
            if (busy === 1'b1) cnt++;
            tick();
        end
        check("busy_cycles", cnt, N);
        check("moved_y", $signed(sy[10:0]), 54);

        // Held request waits out the cooldown, then lands in slot 1.
        fire_wait(-7, 200, frames);
        check("cooldown_frames", frames + 1, COOL);
        check("second_active", act, 4'b0011);
        check("second_x", $signed(sx[21:11]), -7);

        // Shot near the bottom retires; the next fire reuses slot 0.
        do_reset();
        fx = 11'sd20; fy = 11'sd478; freq = 1'b1;
        tick();
        frame();
        check("retired_active", act, 0);
        fire_wait(30, 10, frames);
        check("reuse_active", act, 4'b0001);
        check("reuse_y", $signed(sy[10:0]), 10);

        // Full pool: no ack until a hit frees slot 2.
        do_reset();
        for (int i = 0; i < N; i++) fire_wait(10 * i, -1000, frames);
        check("full_active", act, 4'b1111);
        repeat (COOL) frame();
        acks0 = n_acks;
        fx = 11'sd77; fy = -11'sd500; freq = 1'b1;
        idle(8);
        check("full_no_ack", n_acks - acks0, 0);
        hit = 4'b0100;
        tick();
        hit = '0;
        check("hit_active", act, 4'b1011);
        tick();
        check("refill_ack", fack, 1);
        check("refill_active", act, 4'b1111);
        check("refill_y", $signed(sy[32:22]), -500);

        // startOfFrame beats a simultaneous fire; ack follows the MOVE.
        do_reset();
        fx = 11'sd5; fy = 11'sd5; freq = 1'b1; sof = 1'b1;
        tick();
        sof = 1'b0;
        cnt = 0;
        while (fack !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        check("sof_wins_latency", cnt, N + 1);

        // Reset in the middle of a MOVE clears everything at the next edge.
        sof = 1'b1;
        tick();
        sof = 1'b0;
        idle(2);
        check("mid_move_busy", busy, 1);
        reset = 1'b1;
        tick();
        check_all_zero("mid_move_reset");
        reset = 1'b0;
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            sof = ($urandom_range(0, 9) == 0);
            ge  = ($urandom_range(0, 19) != 0);
            if (!freq && $urandom_range(0, 3) == 0) begin
                freq = 1'b1;
                fx   = 11'($urandom);
                fy   = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 479));
            end
            for (int i = 0; i < N; i++) hit[i] = m_act[i] && ($urandom_range(0, 63) == 0);
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; sof = 1'b0; freq = 1'b0; hit = '0; ge = 1'b1;
        idle(N + 4);
        check("ack_queue_drained", ack_q.size(), 0);
        check("frame_queue_drained", frame_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/monster_shot_scheduler.md
# monster_shot_scheduler

Allocates and sequences the pool of enemy (monster) shots. It accepts fire requests from the monster-matrix logic, assigns each request to a free shot slot, and advances every active shot down the screen once per frame. It retires shots that leave the screen or are reported hit. Per-slot top-left coordinates and active flags drive one square shot-object instance per slot in the VGA drawing chain.

## Interface
Parameters:
- NUM_SHOTS, 4, number of shot slots (1..8)
- SHOT_SPEED, 4, pixels added to Y per frame
- SCREEN_BOTTOM, 480, Y at or beyond which a shot retires
- FIRE_COOLDOWN, 30, frames between accepted fire requests

Ports:
- clk  in  1  system clock
- reset  in  1  one clock; reset is synchronous and active-high
- startOfFrame  in  1  one-cycle pulse per VGA frame
- game_enable  in  1  0 = freeze (no moves, no fires)
- fire_req  in  1  level request from the monster matrix; held until acked
- fire_x  in  11 signed  spawn top-left X
- fire_y  in  11 signed  spawn top-left Y
- fire_ack  out  1  one-cycle pulse when the request is accepted
- shot_hit  in  NUM_SHOTS  per-slot collision pulse; clears that slot
- shot_active  out  NUM_SHOTS  per-slot valid flag
- shot_x  out  NUM_SHOTS×11 signed  packed top-left X; slot i occupies [11i+10:11i]
- shot_y  out  NUM_SHOTS×11 signed  packed top-left Y, same packing
- busy  out  1  high while in MOVE

## Operation
FSM states: IDLE, MOVE.
- IDLE:
  - startOfFrame && game_enable → MOVE with slot index = 0.
  - Otherwise, fire is accepted when fire_req && game_enable && cooldown==0 && a slot is free:
    - The lowest-index free slot loads fire_x/fire_y and its active flag is set.
    - fire_ack pulses.
    - cooldown loads FIRE_COOLDOWN.
- MOVE: handles one slot per cycle, index 0..NUM_SHOTS-1.
  - An active slot computes y+SHOT_SPEED in a 12-bit signed intermediate.
  - If that result is ≥ SCREEN_BOTTOM, the active flag clears. Otherwise shot_y updates.
  - Inactive slots are untouched.
  - After the last index the FSM returns to IDLE, and cooldown decrements if it is nonzero.
- shot_hit[i] clears active[i] in any state on the cycle it is sampled. It takes priority over a move or fire load of the same slot in that cycle.
- shot_x and shot_y of an inactive slot hold their last value. Consumers gate with shot_active.
- When game_enable=0, slot state and cooldown hold. shot_hit is still honoured.
- Cooldown counts frames and saturates at 0.

## Timing
- Reset values:
  - state=IDLE, index=0, cooldown=0.
  - shot_active=0, shot_x=0, shot_y=0.
  - fire_ack=0, busy=0.
- Reset mid-MOVE aborts immediately. All slots are cleared on the next edge.
- Fire latency: fire_req sampled high in IDLE with the accept conditions met gives fire_ack, shot_active[k] and shot_x/shot_y[k] all valid the next cycle. Registered, one-cycle latency.
- fire_req is held by the requester. No ack is issued while in MOVE, while cooldown>0, or while all slots are full (the full condition). Requests are neither queued nor lost.
- startOfFrame and fire_req arriving in the same IDLE cycle: startOfFrame wins and no ack is issued. The fire is retried after MOVE completes.
- MOVE lasts exactly NUM_SHOTS cycles. busy is high for those cycles, starting the cycle after startOfFrame. Slot i is updated at the edge ending MOVE cycle i.
- startOfFrame during MOVE is ignored.
- All slots free (the empty condition): MOVE still runs its NUM_SHOTS cycles with no effect.
- The spawn Y is used as given, with no clipping. A spawn at y ≥ SCREEN_BOTTOM retires on the next MOVE.

## Structure
- Shared package monster_shot_pkg holds:
  - the coordinate typedef (logic signed [10:0]);
  - the FSM state enum;
  - the default constants SHOT_SPEED, SCREEN_BOTTOM and FIRE_COOLDOWN.
- Sub-module: shot_slot_alloc, a combinational lowest-free-index priority encoder. Outputs are free_idx and any_free.
- Everything else lives in a single always_ff plus next-state logic in monster_shot_scheduler.

## Test plan
- Reset, then fire_req with fire_x=100, fire_y=50 → next cycle fire_ack=1, shot_active=0001, shot_x[0]=100, shot_y[0]=50, cooldown=30.
- One startOfFrame after the shot spawn → busy high for 4 cycles, then shot_y[0]=54.
- Hold fire_req with cooldown active → no ack for 30 frames. On the first IDLE cycle after the 30th MOVE, ack is issued and slot 1 is loaded.
- Slot at y=478 with SHOT_SPEED=4 → after MOVE, shot_active[0]=0. Next fire lands in slot 0 (lowest free).
- All 4 slots full with cooldown=0 → fire_req gets no ack. Pulse shot_hit[2] → active=1011, next cycle ack is issued and slot 2 is reloaded.
- startOfFrame and fire_req in the same cycle → MOVE first with no ack. Ack arrives on the cycle after MOVE ends. Assert reset mid-MOVE → all outputs 0 on the next edge.
